// File: rtl/apu_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apu_frame_pkg
//  Description : Shared constants for the APU frame sequencer: default step
//                tick indices, mode encoding and $4017 data bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package apu_frame_pkg;

    // Default step tick indices (in ACLK ticks)
    localparam int c_STEP1_DEF = 3728;
    localparam int c_STEP2_DEF = 7456;
    localparam int c_STEP3_DEF = 11185;
    localparam int c_STEP4_DEF = 14914;
    localparam int c_STEP5_DEF = 18640;

    // Sequencer mode encoding
    localparam logic c_MODE4 = 1'b0;
    localparam logic c_MODE5 = 1'b1;

    // Bit positions inside the 2-bit DIN bus {D7, D6}
    localparam int c_DIN_MODE = 1;
    localparam int c_DIN_INH  = 0;

endpackage : apu_frame_pkg
`default_nettype wire

// File: rtl/apu_frame_step_dec.sv
`default_nettype none
// ============================================================================
//  Module      : apu_frame_step_dec
//  Description : Combinational decode of the frame counter and mode into the
//                quarter/half-frame strobes, IRQ set request and wrap flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module apu_frame_step_dec
    import apu_frame_pkg::*;
#(
    parameter int CNT_W = 15,
    parameter int STEP1 = c_STEP1_DEF,
    parameter int STEP2 = c_STEP2_DEF,
    parameter int STEP3 = c_STEP3_DEF,
    parameter int STEP4 = c_STEP4_DEF,
    parameter int STEP5 = c_STEP5_DEF
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic             mode,
    output logic             qf,
    output logic             hf,
    output logic             irq_set,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] c_S1   = CNT_W'(STEP1);
    localparam logic [CNT_W-1:0] c_S2   = CNT_W'(STEP2);
    localparam logic [CNT_W-1:0] c_S3   = CNT_W'(STEP3);
    localparam logic [CNT_W-1:0] c_S4   = CNT_W'(STEP4);
    localparam logic [CNT_W-1:0] c_S4P1 = CNT_W'(STEP4 + 1);
    localparam logic [CNT_W-1:0] c_S5   = CNT_W'(STEP5);
    localparam logic [CNT_W-1:0] c_S5P1 = CNT_W'(STEP5 + 1);

    // Map the current count onto the step actions; step 4 only clocks in 4-step mode
    always_comb begin
        qf      = 1'b0;
        hf      = 1'b0;
        irq_set = 1'b0;
        wrap    = 1'b0;
        if (cnt == c_S1) begin
            qf = 1'b1;
        end
        if (cnt == c_S2) begin
            qf = 1'b1;
            hf = 1'b1;
        end
        if (cnt == c_S3) begin
            qf = 1'b1;
        end
        if ((cnt == c_S4) && (mode == c_MODE4)) begin
            qf      = 1'b1;
            hf      = 1'b1;
            irq_set = 1'b1;
        end
        if ((cnt == c_S4P1) && (mode == c_MODE4)) begin
            wrap = 1'b1;
        end
        if ((cnt == c_S5) && (mode == c_MODE5)) begin
            qf = 1'b1;
            hf = 1'b1;
        end
        if ((cnt == c_S5P1) && (mode == c_MODE5)) begin
            wrap = 1'b1;
        end
    end

endmodule : apu_frame_step_dec
`default_nettype wire

// File: rtl/apu_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module      : apu_frame_sched
//  Description : APU frame sequencer. Counts ACLK ticks, issues quarter-frame
//                and half-frame strobes in 4-step / 5-step mode and raises
//                the frame IRQ. Configured by $4017 writes, acknowledged by
//                $4015 reads.
//                Optional build macro APU_FRAME_DBG_EN adds a DBG freeze
//                input and a DBG_STEP last-step output.
//  Revision    : 1.0 - initial release
// ============================================================================
module apu_frame_sched
    import apu_frame_pkg::*;
#(
    parameter int CNT_W = 15,
    parameter int STEP1 = c_STEP1_DEF,
    parameter int STEP2 = c_STEP2_DEF,
    parameter int STEP3 = c_STEP3_DEF,
    parameter int STEP4 = c_STEP4_DEF,
    parameter int STEP5 = c_STEP5_DEF
) (
    input  logic       CLK,
    input  logic       RES,
`ifdef APU_FRAME_DBG_EN
    input  logic       DBG,
    output logic [2:0] DBG_STEP,
`endif
    input  logic       ACLK_EN,
    input  logic       W4017,
    input  logic [1:0] DIN,
    input  logic       R4015,
    output logic       QF,
    output logic       HF,
    output logic       FRAME_IRQ
);

    localparam logic [CNT_W-1:0] c_S1 = CNT_W'(STEP1);
    localparam logic [CNT_W-1:0] c_S2 = CNT_W'(STEP2);
    localparam logic [CNT_W-1:0] c_S3 = CNT_W'(STEP3);
    localparam logic [CNT_W-1:0] c_S4 = CNT_W'(STEP4);
    localparam logic [CNT_W-1:0] c_S5 = CNT_W'(STEP5);

    logic [CNT_W-1:0] r_cnt;
    logic             r_mode;
    logic             r_inhibit;
    logic             r_pend;
    logic             r_qf;
    logic             r_hf;
    logic             r_irq;

    logic             w_tick;
    logic             w_dec_qf;
    logic             w_dec_hf;
    logic             w_dec_irq_set;
    logic             w_dec_wrap;
    logic             w_irq_set;
    logic             w_irq_next;

`ifdef APU_FRAME_DBG_EN
    // The debug freeze simply hides ticks from the sequencer
    assign w_tick = ACLK_EN & ~DBG;
`else
    assign w_tick = ACLK_EN;
`endif

    apu_frame_step_dec #(
        .CNT_W (CNT_W),
        .STEP1 (STEP1),
        .STEP2 (STEP2),
        .STEP3 (STEP3),
        .STEP4 (STEP4),
        .STEP5 (STEP5)
    ) u_step_dec (
        .cnt     (r_cnt),
        .mode    (r_mode),
        .qf      (w_dec_qf),
        .hf      (w_dec_hf),
        .irq_set (w_dec_irq_set),
        .wrap    (w_dec_wrap)
    );

    // A pending restart takes priority over step decode on the tick it is serviced
    assign w_irq_set = w_tick & ~r_pend & w_dec_irq_set & ~r_inhibit;

    // IRQ priority: acknowledge < step-4 set < inhibit write
    always_comb begin
        w_irq_next = r_irq;
        if (R4015) begin
            w_irq_next = 1'b0;
        end
        if (w_irq_set) begin
            w_irq_next = 1'b1;
        end
        if (W4017 && DIN[c_DIN_INH]) begin
            w_irq_next = 1'b0;
        end
    end

    // Sequencer state: tick processing uses the old mode/pend, a write on the same edge latches afterwards
    always_ff @(posedge CLK) begin
        if (RES) begin
            r_cnt     <= '0;
            r_mode    <= c_MODE4;
            r_inhibit <= 1'b0;
            r_pend    <= 1'b0;
            r_qf      <= 1'b0;
            r_hf      <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_qf <= 1'b0;
            r_hf <= 1'b0;
            if (w_tick) begin
                if (r_pend) begin
                    r_cnt  <= '0;
                    r_pend <= 1'b0;
                    if (r_mode == c_MODE5) begin
                        r_qf <= 1'b1;
                        r_hf <= 1'b1;
                    end
                end else begin
                    r_qf  <= w_dec_qf;
                    r_hf  <= w_dec_hf;
                    r_cnt <= w_dec_wrap ? '0 : (r_cnt + 1'b1);
                end
            end
            if (W4017) begin
                r_mode    <= DIN[c_DIN_MODE];
                r_inhibit <= DIN[c_DIN_INH];
                r_pend    <= 1'b1;
            end
            r_irq <= w_irq_next;
        end
    end

    assign QF        = r_qf;
    assign HF        = r_hf;
    assign FRAME_IRQ = r_irq;

`ifdef APU_FRAME_DBG_EN
    logic [2:0] r_dbg_step;
    logic [2:0] w_step_idx;

    // Index of the step issued on this count, 0 when the count is not an issuing step
    always_comb begin
        w_step_idx = 3'd0;
        if (r_cnt == c_S1) begin
            w_step_idx = 3'd1;
        end else if (r_cnt == c_S2) begin
            w_step_idx = 3'd2;
        end else if (r_cnt == c_S3) begin
            w_step_idx = 3'd3;
        end else if ((r_cnt == c_S4) && (r_mode == c_MODE4)) begin
            w_step_idx = 3'd4;
        end else if ((r_cnt == c_S5) && (r_mode == c_MODE5)) begin
            w_step_idx = 3'd5;
        end
    end

    // Remember the last issued step; a restart clears it
    always_ff @(posedge CLK) begin
        if (RES) begin
            r_dbg_step <= 3'd0;
        end else if (w_tick) begin
            if (r_pend) begin
                r_dbg_step <= 3'd0;
            end else if (w_step_idx != 3'd0) begin
                r_dbg_step <= w_step_idx;
            end
        end
    end

    assign DBG_STEP = r_dbg_step;
`else
    // Step constants only feed the debug step index
    logic w_unused_steps;
    assign w_unused_steps = ^{c_S1, c_S2, c_S3, c_S4, c_S5};
`endif

endmodule : apu_frame_sched
`default_nettype wire

// File: tb/tb_apu_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apu_frame_sched
//  Description : Self-checking bench for apu_frame_sched with shortened step
//                indices 4/8/12/16/20. Tick vectors are table driven; reset,
//                IRQ-acknowledge races and debug freeze are hand sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apu_frame_sched;

    logic       CLK;
    logic       RES;
    logic       ACLK_EN;
    logic       W4017;
    logic [1:0] DIN;
    logic       R4015;
    logic       QF;
    logic       HF;
    logic       FRAME_IRQ;
`ifdef APU_FRAME_DBG_EN
    logic       DBG;
    logic [2:0] DBG_STEP;
`endif

    int total;
    int bad;

    typedef struct {
        logic       w;
        logic       r;
        logic [1:0] d;
        logic       qf;
        logic       hf;
        logic       irq;
    } vec_t;

    vec_t tbl[$];

    apu_frame_sched #(
        .CNT_W (15),
        .STEP1 (4),
        .STEP2 (8),
        .STEP3 (12),
        .STEP4 (16),
        .STEP5 (20)
    ) dut (
        .CLK       (CLK),
        .RES       (RES),
`ifdef APU_FRAME_DBG_EN
        .DBG       (DBG),
        .DBG_STEP  (DBG_STEP),
`endif
        .ACLK_EN   (ACLK_EN),
        .W4017     (W4017),
        .DIN       (DIN),
        .R4015     (R4015),
        .QF        (QF),
        .HF        (HF),
        .FRAME_IRQ (FRAME_IRQ)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One CLK edge with the given inputs; returns #1 after the edge
    task automatic cyc(input logic aen, input logic w, input logic r, input logic [1:0] d);
        ACLK_EN = aen;
        W4017   = w;
        R4015   = r;
        DIN     = d;
        @(posedge CLK);
        #1;
        ACLK_EN = 1'b0;
        W4017   = 1'b0;
        R4015   = 1'b0;
        DIN     = 2'b00;
    endtask

    function automatic vec_t mk(logic w, logic r, logic [1:0] d, logic qf, logic hf, logic irq);
        vec_t v;
        v.w = w; v.r = r; v.d = d; v.qf = qf; v.hf = hf; v.irq = irq;
        return v;
    endfunction

    // Each vector is one tick edge followed by one idle edge (ACLK_EN every 2nd CLK)
    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(1'b1, tbl[i].w, tbl[i].r, tbl[i].d);
            check($sformatf("%s_qf[%0d]", tag, i), {7'd0, QF}, {7'd0, tbl[i].qf});
            check($sformatf("%s_hf[%0d]", tag, i), {7'd0, HF}, {7'd0, tbl[i].hf});
            check($sformatf("%s_irq[%0d]", tag, i), {7'd0, FRAME_IRQ}, {7'd0, tbl[i].irq});
            cyc(1'b0, 1'b0, 1'b0, 2'b00);
            check($sformatf("%s_qf_idle[%0d]", tag, i), {7'd0, QF}, 8'd0);
            check($sformatf("%s_hf_idle[%0d]", tag, i), {7'd0, HF}, 8'd0);
        end
        tbl.delete();
    endtask

    initial begin
        int c;
        total   = 0;
        bad     = 0;
        RES     = 1'b1;
        ACLK_EN = 1'b0;
        W4017   = 1'b0;
        R4015   = 1'b0;
        DIN     = 2'b00;
`ifdef APU_FRAME_DBG_EN
        DBG     = 1'b0;
`endif
        repeat (3) @(posedge CLK);
        #1;
        check("rst_qf", {7'd0, QF}, 8'd0);
        check("rst_hf", {7'd0, HF}, 8'd0);
        check("rst_irq", {7'd0, FRAME_IRQ}, 8'd0);
`ifdef APU_FRAME_DBG_EN
        check("rst_dbg_step", {5'd0, DBG_STEP}, 8'd0);
`endif
        RES = 1'b0;

        // 1: 40 ticks in 4-step mode, period 18 ticks, IRQ latched from cnt 16
        for (int t = 0; t < 40; t++) begin
            c = t % 18;
            tbl.push_back(mk(1'b0, 1'b0, 2'b00,
                             (c == 4 || c == 8 || c == 12 || c == 16),
                             (c == 8 || c == 16),
                             (t >= 16)));
        end
        run_table("t1");

        // 3: inhibit write clears the pending IRQ and suppresses the next step-4 set
        cyc(1'b0, 1'b1, 1'b0, 2'b01);
        check("t3_irq_clr", {7'd0, FRAME_IRQ}, 8'd0);
        tbl.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
        for (int k = 0; k < 18; k++) begin
            tbl.push_back(mk(1'b0, 1'b0, 2'b00,
                             (k == 4 || k == 8 || k == 12 || k == 16),
                             (k == 8 || k == 16), 1'b0));
        end
        run_table("t3");

        // 2: switch to 5-step mode; restart clocks immediately, period 22 ticks
        cyc(1'b0, 1'b1, 1'b0, 2'b10);
        tbl.push_back(mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0));
        for (int k = 0; k < 26; k++) begin
            c = k % 22;
            tbl.push_back(mk(1'b0, 1'b0, 2'b00,
                             (c == 4 || c == 8 || c == 12 || c == 20),
                             (c == 8 || c == 20), 1'b0));
        end
        run_table("t2");

        // 4: back to 4-step, IRQ enabled; acknowledge coinciding with the set loses
        cyc(1'b0, 1'b1, 1'b0, 2'b00);
        tbl.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
        for (int k = 0; k < 16; k++) begin
            tbl.push_back(mk(1'b0, 1'b0, 2'b00,
                             (k == 4 || k == 8 || k == 12), (k == 8), 1'b0));
        end
        run_table("t4pre");
        cyc(1'b1, 1'b0, 1'b1, 2'b00);
        check("t4_race_qf", {7'd0, QF}, 8'd1);
        check("t4_race_hf", {7'd0, HF}, 8'd1);
        check("t4_race_irq", {7'd0, FRAME_IRQ}, 8'd1);
        cyc(1'b0, 1'b0, 1'b1, 2'b00);
        check("t4_ack_irq", {7'd0, FRAME_IRQ}, 8'd0);
        // next tick processes cnt 17 (wrap), no strobe
        cyc(1'b1, 1'b0, 1'b0, 2'b00);
        check("t4_wrap_qf", {7'd0, QF}, 8'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'b00);

        // 5: 5-step mode up to cnt 10, pending write, then reset on a tick+write edge
        cyc(1'b0, 1'b1, 1'b0, 2'b10);
        tbl.push_back(mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0));
        for (int k = 0; k < 10; k++) begin
            tbl.push_back(mk(1'b0, 1'b0, 2'b00, (k == 4 || k == 8), (k == 8), 1'b0));
        end
        run_table("t5pre");
        cyc(1'b0, 1'b1, 1'b0, 2'b10);
        RES = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 2'b10);
        RES = 1'b0;
        check("t5_rst_qf", {7'd0, QF}, 8'd0);
        check("t5_rst_hf", {7'd0, HF}, 8'd0);
        check("t5_rst_irq", {7'd0, FRAME_IRQ}, 8'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'b00);
        for (int k = 0; k < 18; k++) begin
            tbl.push_back(mk(1'b0, 1'b0, 2'b00,
                             (k == 4 || k == 8 || k == 12 || k == 16),
                             (k == 8 || k == 16), (k >= 16)));
        end
        run_table("t5");

`ifdef APU_FRAME_DBG_EN
        // 6: freeze at cnt 6, then resume where it stopped
        RES = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 2'b00);
        RES = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tbl.push_back(mk(1'b0, 1'b0, 2'b00, (k == 4), 1'b0, 1'b0));
        end
        run_table("t6pre");
        check("t6_step_before", {5'd0, DBG_STEP}, 8'd1);
        DBG = 1'b1;
        for (int k = 0; k < 30; k++) begin
            cyc((k % 2) == 0, 1'b0, 1'b0, 2'b00);
            check($sformatf("t6_frz_qf[%0d]", k), {7'd0, QF}, 8'd0);
            check($sformatf("t6_frz_hf[%0d]", k), {7'd0, HF}, 8'd0);
        end
        check("t6_step_frozen", {5'd0, DBG_STEP}, 8'd1);
        DBG = 1'b0;
        tbl.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0));
        run_table("t6");
        check("t6_step_after", {5'd0, DBG_STEP}, 8'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_apu_frame_sched
`default_nettype wire
